// File: rtl/collision_scanner.sv
// Collision scanner: once per frame, probes the tile map at SAMPLES points just outside each
// edge of the character hitbox and ORs the answers into per-side blocked flags
// {left, right, up, down}. Probes that leave the screen are clamped. A clamp along a side's
// primary axis marks that side as walled.
module collision_scanner #(
    parameter int COORD_W  = 10,
    parameter int BOX_W    = 42,
    parameter int BOX_H    = 56,
    parameter int SAMPLES  = 3,
    parameter int MARGIN   = 1,
    parameter int MAP_LAT  = 1,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [COORD_W-1:0] char_x,
    input  logic [COORD_W-1:0] char_y,
    output logic [COORD_W-1:0] query_x,
    output logic [COORD_W-1:0] query_y,
    output logic               query_valid,
    input  logic               query_solid,
    output logic [3:0]         stop_at,
    output logic               busy,
    output logic               done
);

    localparam int SW = COORD_W + 2;
    localparam int KW = $clog2(SAMPLES);

    typedef logic signed [SW-1:0] sc_t;

    localparam sc_t HW     = sc_t'(BOX_W / 2);
    localparam sc_t HH     = sc_t'(BOX_H / 2);
    localparam sc_t MG     = sc_t'(MARGIN);
    localparam sc_t STEP_X = sc_t'((BOX_W - 2) / (SAMPLES - 1));
    localparam sc_t STEP_Y = sc_t'((BOX_H - 2) / (SAMPLES - 1));
    localparam sc_t SPAN_X = sc_t'(BOX_W - 2);
    localparam sc_t SPAN_Y = sc_t'(BOX_H - 2);
    localparam sc_t LIM_X  = sc_t'(SCREEN_W);
    localparam sc_t LIM_Y  = sc_t'(SCREEN_H);
    localparam logic [KW-1:0] KLast = KW'(SAMPLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e               state_q;
    logic [COORD_W-1:0]   cx_q, cy_q;
    logic [2:0]           side_q;      // side of the next probe; 4 means all issued
    logic [KW-1:0]        k_q;         // sample index of the next probe
    logic [3:0]           acc_q;
    logic [3:0]           wall_q;
    logic [1:0]           query_tag;
    logic [MAP_LAT-1:0]      pipe_v;
    logic [MAP_LAT-1:0][1:0] pipe_t;

    // Probe generation signals
    logic [COORD_W-1:0] base_x, base_y;
    logic [1:0]         p_side;
    logic [KW-1:0]      p_k, nxt_k;
    logic [2:0]         nxt_side;
    sc_t                bx, by, off_x, off_y, samp_x, samp_y, raw_x, raw_y;
    logic               x_lo, x_hi, y_lo, y_hi;
    logic [COORD_W-1:0] px, py;
    logic [3:0]         p_wall;

    // Response handling signals
    logic [3:0] resp_bits, acc_nxt;
    logic       drain_last;

    // Geometry of the probe that will be registered at the next edge, with clamping.
    // In IDLE it is the first probe of a new scan, taken straight from the char inputs.
    always_comb begin
        base_x   = cx_q;
        base_y   = cy_q;
        p_side   = side_q[1:0];
        p_k      = k_q;
        if (state_q == StIdle) begin
            base_x = char_x;
            base_y = char_y;
            p_side = 2'd0;
            p_k    = '0;
        end
        nxt_k    = p_k + KW'(1);
        nxt_side = {1'b0, p_side};
        if (p_k == KLast) begin
            nxt_k    = '0;
            nxt_side = {1'b0, p_side} + 3'd1;
        end

        bx     = sc_t'(base_x);
        by     = sc_t'(base_y);
        // The last sample lands exactly on the far corner regardless of rounding in STEP.
        off_x  = (p_k == KLast) ? SPAN_X : sc_t'(p_k) * STEP_X;
        off_y  = (p_k == KLast) ? SPAN_Y : sc_t'(p_k) * STEP_Y;
        samp_x = bx - HW + sc_t'(1) + off_x;
        samp_y = by - HH + sc_t'(1) + off_y;

        raw_x = samp_x;
        raw_y = samp_y;
        unique case (p_side)
            2'd0: raw_x = bx - HW - MG;
            2'd1: raw_x = bx + HW + MG;
            2'd2: raw_y = by - HH - MG;
            2'd3: raw_y = by + HH + MG;
        endcase

        x_lo = raw_x < 0;
        x_hi = raw_x >= LIM_X;
        y_lo = raw_y < 0;
        y_hi = raw_y >= LIM_Y;
        px   = x_lo ? '0 : (x_hi ? COORD_W'(SCREEN_W - 1) : raw_x[COORD_W-1:0]);
        py   = y_lo ? '0 : (y_hi ? COORD_W'(SCREEN_H - 1) : raw_y[COORD_W-1:0]);

        p_wall = 4'b0000;
        if (p_side[1] ? (y_lo | y_hi) : (x_lo | x_hi)) begin
            p_wall = 4'b1000 >> p_side;
        end
    end

    // Map responses that belong to the probe at the pipe tail; drain ends when only the
    // tail may still hold a pending probe.
    always_comb begin
        resp_bits = 4'b0000;
        if (pipe_v[MAP_LAT-1] && query_solid) begin
            resp_bits = 4'b1000 >> pipe_t[MAP_LAT-1];
        end
        acc_nxt    = acc_q | resp_bits;
        drain_last = 1'b1;
        for (int i = 0; i < MAP_LAT - 1; i++) begin
            if (pipe_v[i]) begin
                drain_last = 1'b0;
            end
        end
    end

    // Side-tag pipe aligned with the tile-map read latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pipe_v <= '0;
            pipe_t <= '0;
        end else begin
            pipe_v[0] <= query_valid;
            pipe_t[0] <= query_tag;
            for (int i = 1; i < MAP_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_t[i] <= pipe_t[i-1];
            end
        end
    end

    // Scan FSM with registered probe, flag and status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            cx_q        <= '0;
            cy_q        <= '0;
            side_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            wall_q      <= '0;
            query_tag   <= '0;
            query_x     <= '0;
            query_y     <= '0;
            query_valid <= 1'b0;
            stop_at     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            acc_q <= acc_nxt;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cx_q        <= char_x;
                        cy_q        <= char_y;
                        acc_q       <= '0;
                        wall_q      <= p_wall;
                        query_x     <= px;
                        query_y     <= py;
                        query_tag   <= p_side;
                        query_valid <= 1'b1;
                        side_q      <= nxt_side;
                        k_q         <= nxt_k;
                        busy        <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (side_q == 3'd4) begin
                        query_valid <= 1'b0;
                        state_q     <= StDrain;
                    end else begin
                        wall_q    <= wall_q | p_wall;
                        query_x   <= px;
                        query_y   <= py;
                        query_tag <= p_side;
                        side_q    <= nxt_side;
                        k_q       <= nxt_k;
                    end
                end
                StDrain: begin
                    if (drain_last) begin
                        stop_at <= acc_nxt | wall_q;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: two instances (default and SAMPLES=4/MAP_LAT=3) driven in
// lockstep, tile-map responders, and a geometric reference model of the probe pattern.
module tb_collision_scanner;

    localparam int CW = 10;
    localparam int SA = 3;
    localparam int LA = 1;
    localparam int SB = 4;
    localparam int LB = 3;

    logic          Clk = 1'b0;
    logic          Reset, start;
    logic [CW-1:0] char_x, char_y;
    logic [CW-1:0] qx_a, qy_a, qx_b, qy_b;
    logic          qv_a, qv_b, qs_a, qs_b;
    logic [3:0]    stop_a, stop_b;
    logic          busy_a, busy_b, done_a, done_b;

    always #5 Clk = ~Clk;

    collision_scanner u_dut_a (
        .Clk(Clk), .Reset(Reset), .start(start), .char_x(char_x), .char_y(char_y),
        .query_x(qx_a), .query_y(qy_a), .query_valid(qv_a), .query_solid(qs_a),
        .stop_at(stop_a), .busy(busy_a), .done(done_a)
    );

    collision_scanner #(.SAMPLES(SB), .MAP_LAT(LB)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .start(start), .char_x(char_x), .char_y(char_y),
        .query_x(qx_b), .query_y(qy_b), .query_valid(qv_b), .query_solid(qs_b),
        .stop_at(stop_b), .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Tile map: 0 = empty, 1 = single solid tile, 2 = pseudo-random scatter
    int map_mode = 0;
    int pt_x = 0, pt_y = 0, seed = 0;

    function automatic bit map_solid(input int x, input int y);
        case (map_mode)
            1:       return (x == pt_x) && (y == pt_y);
            2:       return ((x * 31 + y * 17 + seed) % 11) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Map responders: answer exactly the read latency after each probe, noise otherwise
    logic          noise = 1'b0;
    logic          rsp_a = 1'b0, vld_a = 1'b0;
    logic [LB-1:0] rsp_b = '0, vld_b = '0;

    always @(posedge Clk) begin
        noise <= 1'($urandom);
        vld_a <= qv_a;
        rsp_a <= qv_a && map_solid(int'(qx_a), int'(qy_a));
        vld_b <= {vld_b[LB-2:0], qv_b};
        rsp_b <= {rsp_b[LB-2:0], qv_b && map_solid(int'(qx_b), int'(qy_b))};
    end

    assign qs_a = vld_a ? rsp_a : noise;
    assign qs_b = vld_b[LB-1] ? rsp_b[LB-1] : noise;

    // Monitor: probe log and done pulses, timed relative to the start cycle t0
    int cyc = 0;
    int t0  = 0;
    int pa_x[$], pa_y[$], pa_c[$], pb_x[$], pb_y[$], pb_c[$];
    int da_n = 0, da_c = -1, db_n = 0, db_c = -1;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (qv_a) begin
            pa_x.push_back(int'(qx_a)); pa_y.push_back(int'(qy_a)); pa_c.push_back(cyc - t0);
        end
        if (qv_b) begin
            pb_x.push_back(int'(qx_b)); pb_y.push_back(int'(qy_b)); pb_c.push_back(cyc - t0);
        end
        if (done_a) begin da_n++; da_c = cyc - t0; end
        if (done_b) begin db_n++; db_c = cyc - t0; end
    end

    // Reference model: probe i walks left, right, up, down with s samples each
    function automatic int samp(input int c, input int h, input int box, input int s,
                                input int k);
        if (k == s - 1) return c + h - 1;
        return c - h + 1 + k * ((box - 2) / (s - 1));
    endfunction

    function automatic int raw_x(input int s, input int i, input int cx);
        case (i / s)
            0:       return cx - 21 - 1;
            1:       return cx + 21 + 1;
            default: return samp(cx, 21, 42, s, i % s);
        endcase
    endfunction

    function automatic int raw_y(input int s, input int i, input int cy);
        case (i / s)
            2:       return cy - 28 - 1;
            3:       return cy + 28 + 1;
            default: return samp(cy, 28, 56, s, i % s);
        endcase
    endfunction

    function automatic int clampv(input int v, input int lim);
        if (v < 0) return 0;
        if (v >= lim) return lim - 1;
        return v;
    endfunction

    function automatic int mdl_stop(input int s, input int cx, input int cy);
        int res = 0;
        for (int i = 0; i < 4 * s; i++) begin
            int rx = raw_x(s, i, cx);
            int ry = raw_y(s, i, cy);
            bit wall = (i / s < 2) ? (rx < 0 || rx >= 640) : (ry < 0 || ry >= 480);
            if (wall || map_solid(clampv(rx, 640), clampv(ry, 480))) res |= 8 >> (i / s);
        end
        return res;
    endfunction

    task automatic check_scan(input string nm, input int d, input int cx, input int cy);
        int s, lat, dn, dc, st, bz;
        int px[$], py[$], pc[$];
        if (d == 0) begin
            s = SA; lat = LA; dn = da_n; dc = da_c; st = int'(stop_a); bz = int'(busy_a);
            px = pa_x; py = pa_y; pc = pa_c;
        end else begin
            s = SB; lat = LB; dn = db_n; dc = db_c; st = int'(stop_b); bz = int'(busy_b);
            px = pb_x; py = pb_y; pc = pb_c;
        end
        check_eq($sformatf("%s/d%0d/ndone", nm, d), dn, 1);
        check_eq($sformatf("%s/d%0d/tdone", nm, d), dc, 4 * s + lat + 1);
        check_eq($sformatf("%s/d%0d/nprobe", nm, d), px.size(), 4 * s);
        if (pc.size() > 0) begin
            check_eq($sformatf("%s/d%0d/tfirst", nm, d), pc[0], 1);
            check_eq($sformatf("%s/d%0d/tlast", nm, d), pc[pc.size()-1], 4 * s);
        end
        for (int i = 0; i < px.size() && i < 4 * s; i++) begin
            check_eq($sformatf("%s/d%0d/px%0d", nm, d, i), px[i],
                     clampv(raw_x(s, i, cx), 640));
            check_eq($sformatf("%s/d%0d/py%0d", nm, d, i), py[i],
                     clampv(raw_y(s, i, cy), 480));
        end
        check_eq($sformatf("%s/d%0d/stop", nm, d), st, mdl_stop(s, cx, cy));
        check_eq($sformatf("%s/d%0d/busy", nm, d), bz, 0);
    endtask

    // One scan on both instances; optional stray start at relative cycle restart_at
    task automatic scan(input string nm, input int cx, input int cy, input int restart_at);
        @(negedge Clk);
        pa_x.delete(); pa_y.delete(); pa_c.delete();
        pb_x.delete(); pb_y.delete(); pb_c.delete();
        da_n = 0; db_n = 0; da_c = -1; db_c = -1;
        char_x = CW'(cx);
        char_y = CW'(cy);
        t0     = cyc;
        start  = 1'b1;
        @(negedge Clk);
        start  = 1'b0;
        // Coordinates must be latched at start, so wiggle them during the scan
        char_x = CW'($urandom_range(1023, 0));
        char_y = CW'($urandom_range(1023, 0));
        while (cyc - t0 < 32) begin
            start = (cyc - t0 == restart_at);
            @(negedge Clk);
        end
        start = 1'b0;
        check_scan(nm, 0, cx, cy);
        check_scan(nm, 1, cx, cy);
    endtask

    initial begin
        Reset  = 1'b1;
        start  = 1'b0;
        char_x = '0;
        char_y = '0;
        repeat (3) @(negedge Clk);
        check_eq("rst/a/qv", int'(qv_a), 0);
        check_eq("rst/a/qx", int'(qx_a), 0);
        check_eq("rst/a/qy", int'(qy_a), 0);
        check_eq("rst/a/busy", int'(busy_a), 0);
        check_eq("rst/a/done", int'(done_a), 0);
        check_eq("rst/a/stop", int'(stop_a), 0);
        check_eq("rst/b/qv", int'(qv_b), 0);
        check_eq("rst/b/busy", int'(busy_b), 0);
        check_eq("rst/b/stop", int'(stop_b), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        map_mode = 0;
        scan("clear", 320, 240, -1);
        map_mode = 1; pt_x = 342; pt_y = 240;
        scan("right_hit", 320, 240, -1);
        check_eq("right_hit/a/lit", int'(stop_a), 4);
        map_mode = 0;
        scan("recleared", 320, 240, -1);
        scan("wall_left", 15, 100, -1);
        check_eq("wall_left/a/lit", int'(stop_a), 8);
        scan("wall_down", 320, 460, -1);
        check_eq("wall_down/a/lit", int'(stop_a), 1);
        scan("restart5", 320, 240, 5);

        // Reset mid-scan with a solid tile under the first probe
        map_mode = 1; pt_x = 298; pt_y = 213;
        @(negedge Clk);
        pa_x.delete(); pa_y.delete(); pa_c.delete();
        pb_x.delete(); pb_y.delete(); pb_c.delete();
        da_n = 0; db_n = 0;
        char_x = 10'd320; char_y = 10'd240;
        t0     = cyc;
        start  = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        while (cyc - t0 < 6) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_eq("midrst/a/qv", int'(qv_a), 0);
        check_eq("midrst/a/stop", int'(stop_a), 0);
        check_eq("midrst/a/busy", int'(busy_a), 0);
        check_eq("midrst/b/qv", int'(qv_b), 0);
        check_eq("midrst/b/stop", int'(stop_b), 0);
        repeat (25) @(negedge Clk);
        check_eq("midrst/a/ndone", da_n, 0);
        check_eq("midrst/b/ndone", db_n, 0);
        check_eq("midrst/a/nprobe", pa_x.size(), 6);
        check_eq("midrst/b/nprobe", pb_x.size(), 6);
        check_eq("midrst/a/stop_late", int'(stop_a), 0);
        scan("after_rst", 320, 240, -1);
        check_eq("after_rst/a/lit", int'(stop_a), 8);

        pt_x = 340; pt_y = 269;
        scan("down_last", 320, 240, -1);
        check_eq("down_last/b/lit", int'(stop_b), 1);

        map_mode = 2;
        for (int n = 0; n < 25; n++) begin
            seed = int'($urandom_range(1000, 0));
            scan($sformatf("rnd%0d", n), int'($urandom_range(700, 0)),
                 int'($urandom_range(520, 0)),
                 ($urandom_range(1, 0) == 1) ? int'($urandom_range(14, 1)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
